// File: rtl/fpu_pkg.sv
// Shared types for the FPU issue controller: FPU_Control codes, op classes,
// controller states and the latency counter width.
package fpu_pkg;

    localparam int CNT_W = 4;

    localparam logic [3:0] FPU_CTRL_ADD  = 4'd0;
    localparam logic [3:0] FPU_CTRL_SUB  = 4'd1;
    localparam logic [3:0] FPU_CTRL_MUL  = 4'd2;
    localparam logic [3:0] FPU_CTRL_DIV  = 4'd3;
    localparam logic [3:0] FPU_CTRL_CMP  = 4'd4;
    localparam logic [3:0] FPU_CTRL_CVT  = 4'd5;
    localparam logic [3:0] FPU_CTRL_SGNJ = 4'd6;

    typedef enum logic [1:0] {
        CLASS_ADD,
        CLASS_MUL,
        CLASS_DIV
    } fpu_class_e;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } issue_state_e;

    // Anything that is not a multiply or divide runs on the short add-class path.
    function automatic fpu_class_e decode_class(input logic [3:0] ctrl);
        case (ctrl)
            FPU_CTRL_MUL: return CLASS_MUL;
            FPU_CTRL_DIV: return CLASS_DIV;
            default:      return CLASS_ADD;
        endcase
    endfunction

endpackage

// File: rtl/fpu_lat_decode.sv
// Maps an FPU_Control code to the BUSY-cycle counter preload (latency - 1).
module fpu_lat_decode
    import fpu_pkg::*;
#(
    parameter int LAT_ADD = 1,
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 8
) (
    input  logic [3:0]       ctrl,
    output logic [CNT_W-1:0] load_cnt
);

    fpu_class_e op_class;

    always_comb begin
        op_class = decode_class(ctrl);
        case (op_class)
            CLASS_MUL: load_cnt = CNT_W'(LAT_MUL - 1);
            CLASS_DIV: load_cnt = CNT_W'(LAT_DIV - 1);
            default:   load_cnt = CNT_W'(LAT_ADD - 1);
        endcase
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Single-outstanding FPU issue controller: holds operands for the op latency,
// then strobes one writeback. Define FPU_ISSUE_FLUSH_EN to add a flush input.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int LAT_ADD = 1,
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 8
) (
    input  logic        CLK,
    input  logic        RST,
`ifdef FPU_ISSUE_FLUSH_EN
    input  logic        flush,
`endif
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [3:0]  issue_ctrl,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    output logic [31:0] fpu_op_a,
    output logic [31:0] fpu_op_b,
    output logic [3:0]  fpu_ctrl,
    input  logic [31:0] fpu_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy
);

    issue_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] load_cnt;
    logic [31:0]      op_a_q, op_a_d;
    logic [31:0]      op_b_q, op_b_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [4:0]       rd_q, rd_d;
    logic             wb_valid_q, wb_valid_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic [4:0]       wb_rd_q, wb_rd_d;
    logic             flush_w;

`ifdef FPU_ISSUE_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    fpu_lat_decode #(
        .LAT_ADD (LAT_ADD),
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV)
    ) u_lat_decode (
        .ctrl     (issue_ctrl),
        .load_cnt (load_cnt)
    );

    assign issue_ready = (state_q == ST_IDLE) && !flush_w;
    assign busy        = (state_q == ST_BUSY);
    assign fpu_op_a    = op_a_q;
    assign fpu_op_b    = op_b_q;
    assign fpu_ctrl    = ctrl_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        ctrl_d     = ctrl_q;
        rd_d       = rd_q;
        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;

        case (state_q)
            ST_IDLE: begin
                if (issue_valid && issue_ready) begin
                    op_a_d  = issue_a;
                    op_b_d  = issue_b;
                    ctrl_d  = issue_ctrl;
                    rd_d    = issue_rd;
                    cnt_d   = load_cnt;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // The FPU result is taken in the last BUSY cycle so the strobe
                // lands in the first IDLE cycle, allowing back-to-back issue.
                if (flush_w) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = fpu_result;
                    wb_rd_d    = rd_q;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            ctrl_q     <= '0;
            rd_q       <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            ctrl_q     <= ctrl_d;
            rd_q       <= rd_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: directed scenarios then random traffic,
// scored against a cycle-number model of issue, latency and writeback.
module tb_fpu_issue_ctrl;

    localparam int LAT_ADD = 1;
    localparam int LAT_MUL = 3;
    localparam int LAT_DIV = 8;
`ifdef FPU_ISSUE_FLUSH_EN
    localparam bit FLUSH_EN = 1'b1;
`else
    localparam bit FLUSH_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_ctrl;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [4:0]  issue_rd;
    logic [31:0] fpu_op_a;
    logic [31:0] fpu_op_b;
    logic [3:0]  fpu_ctrl;
    logic [31:0] fpu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;
`ifdef FPU_ISSUE_FLUSH_EN
    logic        flush;
`endif

    logic        fixed_mode = 1'b0;
    logic [31:0] fixed_val  = 32'h0;

    int checks = 0;
    int errors = 0;

    // Model: the cycle number the controller is idle again, the cycle the
    // writeback strobe is due, and what it should carry.
    int          cyc     = 0;
    int          free_at = 0;
    int          wb_at   = -1;
    logic [31:0] m_a = '0, m_b = '0, m_data = '0, last_data = '0;
    logic [3:0]  m_ctrl = '0;
    logic [4:0]  m_rd = '0, last_rd = '0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] res_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] c);
        return (a + b) ^ {28'd0, c};
    endfunction

    function automatic int lat_of(input logic [3:0] c);
        if (c == 4'd2) return LAT_MUL;
        if (c == 4'd3) return LAT_DIV;
        return LAT_ADD;
    endfunction

    assign fpu_result = fixed_mode ? fixed_val : res_fn(fpu_op_a, fpu_op_b, fpu_ctrl);

    fpu_issue_ctrl #(
        .LAT_ADD (LAT_ADD),
        .LAT_MUL (LAT_MUL),
        .LAT_DIV (LAT_DIV)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
`ifdef FPU_ISSUE_FLUSH_EN
        .flush       (flush),
`endif
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_ctrl  (issue_ctrl),
        .issue_a     (issue_a),
        .issue_b     (issue_b),
        .issue_rd    (issue_rd),
        .fpu_op_a    (fpu_op_a),
        .fpu_op_b    (fpu_op_b),
        .fpu_ctrl    (fpu_ctrl),
        .fpu_result  (fpu_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .busy        (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d observed=0x%08h expected=0x%08h",
                     tag, cyc, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, checks the DUT against the model mid-cycle,
    // then advances the model across the rising edge.
    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic rst, input logic fl);
        logic idle, fl_eff, accept;
        issue_valid = v;
        issue_ctrl  = c;
        issue_a     = a;
        issue_b     = b;
        issue_rd    = rd;
        RST         = rst;
`ifdef FPU_ISSUE_FLUSH_EN
        flush       = fl;
`endif
        fl_eff = fl & FLUSH_EN;
        @(negedge CLK);
        idle = (cyc >= free_at);
        if (cyc == wb_at) begin
            last_rd   = m_rd;
            last_data = m_data;
        end
        checkOutput("issue_ready", {31'd0, issue_ready}, {31'd0, idle && !fl_eff});
        checkOutput("busy", {31'd0, busy}, {31'd0, !idle});
        checkOutput("wb_valid", {31'd0, wb_valid}, {31'd0, cyc == wb_at});
        checkOutput("wb_rd", {27'd0, wb_rd}, {27'd0, last_rd});
        checkOutput("wb_data", wb_data, last_data);
        if (!idle) begin
            checkOutput("fpu_op_a", fpu_op_a, m_a);
            checkOutput("fpu_op_b", fpu_op_b, m_b);
            checkOutput("fpu_ctrl", {28'd0, fpu_ctrl}, {28'd0, m_ctrl});
        end
        accept = idle && !fl_eff && v && !rst;
        @(posedge CLK);
        if (rst) begin
            free_at   = cyc + 1;
            wb_at     = -1;
            last_rd   = '0;
            last_data = '0;
            m_a       = '0;
            m_b       = '0;
            m_ctrl    = '0;
        end else if (!idle && fl_eff) begin
            free_at = cyc + 1;
            wb_at   = -1;
        end else if (accept) begin
            wb_at   = cyc + lat_of(c) + 1;
            free_at = wb_at;
            m_a     = a;
            m_b     = b;
            m_ctrl  = c;
            m_rd    = rd;
            m_data  = fixed_mode ? fixed_val : res_fn(a, b, c);
        end
        cyc++;
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic checkZeroOps(input string tag);
        checkOutput({tag, "_op_a"}, fpu_op_a, 32'd0);
        checkOutput({tag, "_op_b"}, fpu_op_b, 32'd0);
        checkOutput({tag, "_ctrl"}, {28'd0, fpu_ctrl}, 32'd0);
        checkOutput({tag, "_wb_data"}, wb_data, 32'd0);
        checkOutput({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        issue_valid = 1'b0;
        issue_ctrl = '0;
        issue_a = '0;
        issue_b = '0;
        issue_rd = '0;
`ifdef FPU_ISSUE_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        checkZeroOps("reset");

        // 1.0 + 2.0 with the FPU returning 3.0, add-class latency.
        fixed_mode = 1'b1;
        fixed_val  = 32'h4040_0000;
        applyStimulus(1'b1, 4'd0, 32'h3F80_0000, 32'h4000_0000, 5'd7, 1'b0, 1'b0);
        idleCycles(3);
        fixed_mode = 1'b0;

        // Divide, with a competing request held through the whole BUSY window.
        applyStimulus(1'b1, 4'd3, 32'h1234_5678, 32'h0BAD_F00D, 5'd9, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++)
            applyStimulus(1'b1, 4'd1, 32'hAAAA_0000 + i, 32'h5555, 5'd20, 1'b0, 1'b0);
        idleCycles(3);

        // Back-to-back add-class ops with issue_valid held high.
        for (int i = 0; i < 12; i++)
            applyStimulus(1'b1, 4'd0, $urandom, $urandom, 5'(i + 1), 1'b0, 1'b0);
        idleCycles(3);

        // Reset in the second BUSY cycle of a multiply.
        applyStimulus(1'b1, 4'd2, 32'hCAFE_0001, 32'hBEEF_0002, 5'd17, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
        checkZeroOps("mul_rst");
        idleCycles(5);

        if (FLUSH_EN) begin
            applyStimulus(1'b1, 4'd3, 32'h0F0F_0F0F, 32'h1111_2222, 5'd3, 1'b0, 1'b0);
            applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
            applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
            idleCycles(10);
            applyStimulus(1'b1, 4'd0, 32'h1, 32'h2, 5'd4, 1'b0, 1'b1);
            idleCycles(3);
        end

        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), $urandom, $urandom,
                          5'($urandom_range(0, 31)), 1'($urandom_range(0, 63) == 0),
                          1'($urandom_range(0, 15) == 0));
        idleCycles(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 Parameter LAT_ADD, default 1: FPU cycles for add/sub/cmp/cvt/sign-inject class, legal 1..15.
REQ-002 Parameter LAT_MUL, default 3: FPU cycles for multiply class, legal 1..15.
REQ-003 Parameter LAT_DIV, default 8: FPU cycles for divide class, legal 1..15.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 issue_valid  in  1  core presents an FP operation.
REQ-007 issue_ready  out  1  controller accepts an operation this cycle.
REQ-008 issue_ctrl  in  4  FPU_Control code of the operation.
REQ-009 issue_a, issue_b  in  32 each  IEEE-754 single operands.
REQ-010 issue_rd  in  5  destination FP register.
REQ-011 fpu_op_a, fpu_op_b  out  32 each  held operands driven to the FPU.
REQ-012 fpu_ctrl  out  4  held FPU_Control driven to the FPU.
REQ-013 fpu_result  in  32  FPU Result.
REQ-014 wb_valid  out  1  one-cycle writeback strobe.
REQ-015 wb_rd  out  5; wb_data  out  32  writeback destination and value.
REQ-016 busy  out  1  operation in flight (core stall source).

Function
REQ-017 States SHALL be IDLE and BUSY; issue_ready SHALL equal (state==IDLE).
REQ-018 Handshake: issue_valid & issue_ready at an edge SHALL latch issue_ctrl/a/b/rd into fpu_ctrl/fpu_op_a/fpu_op_b/rd register, load count = LAT(class)-1, go BUSY.
REQ-019 Class decode: issue_ctrl 4'd2 = MUL, 4'd3 = DIV, every other code = ADD class.
REQ-020 fpu_op_a, fpu_op_b, fpu_ctrl SHALL stay constant from acceptance until return to IDLE.
REQ-021 BUSY with count != 0: count decrements by 1 per cycle.
REQ-022 BUSY with count == 0: capture fpu_result into wb_data, rd into wb_rd, set wb_valid for the next cycle only, go IDLE.
REQ-023 Latency: accepted in cycle N -> wb_valid high in cycle N+LAT+1, exactly one cycle.
REQ-024 The cycle wb_valid is high the state SHALL be IDLE, so a new issue can be accepted in that same cycle (back-to-back).
REQ-025 busy SHALL equal (state==BUSY); issue_valid while BUSY is ignored, with no queueing.
REQ-026 wb_data and wb_rd SHALL hold their last value while wb_valid is low.

Reset
REQ-027 RST high at an edge SHALL force IDLE, count 0, wb_valid 0, wb_data 0, wb_rd 0, fpu_op_a 0, fpu_op_b 0, fpu_ctrl 0, regardless of state.
REQ-028 Reset mid-operation SHALL discard the in-flight operation with no wb_valid; issue_ready is high in the first cycle after reset.

Configuration
REQ-029 With macro FPU_ISSUE_FLUSH_EN defined, input flush (1 bit) SHALL exist: in BUSY, flush forces IDLE at the next edge with no wb_valid; in IDLE, flush blocks acceptance by forcing issue_ready low.
REQ-030 Without FPU_ISSUE_FLUSH_EN, no flush port exists and operations always complete.

Structure
REQ-031 Package fpu_pkg SHALL hold the FPU_Control encodings, the class enum (ADD/MUL/DIV), the state enum, and the 4-bit count width constant.
REQ-032 One sub-module fpu_lat_decode SHALL map issue_ctrl and the parameters to the 4-bit load count; everything else stays in fpu_issue_ctrl.

Verification
REQ-033 Reset, then issue ctrl=0, a=0x3F800000, b=0x40000000 in cycle 1, with fpu_result returning 0x40400000 -> wb_valid in cycle 3, wb_data=0x40400000, wb_rd as issued.
REQ-034 Issue DIV (ctrl=3) with LAT_DIV=8 in cycle N -> busy high cycles N+1..N+8, issue_ready low, wb_valid in cycle N+9; a second issue_valid during BUSY is not accepted.
REQ-035 Back-to-back ADD ops with issue_valid held high -> an acceptance every 2 cycles, each acceptance coinciding with the previous op's wb_valid cycle, and wb_rd values in order.
REQ-036 RST asserted in the 2nd cycle of a MUL -> next cycle IDLE, wb_valid never pulses, all outputs 0.
REQ-037 With FPU_ISSUE_FLUSH_EN defined, flush in cycle N+2 of a DIV -> IDLE in N+3, no wb_valid; flush with issue_valid in IDLE -> not accepted.
